memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter that shares one off-chip line-read channel
// between the instruction cache (req0) and the data cache (req1).
module memory_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_read_enable,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  output logic                  req0_read_ready,
  input  logic                  req1_read_enable,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  output logic                  req1_read_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  memory_read_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  memory_read_ready,
  input  logic [DATA_WIDTH-1:0] memory_data,
  output logic [1:0]            grant
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  prio1_q, prio1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  pick0;

  // req0 wins when alone, or on a tie while req1 does not hold the priority token
  assign pick0 = req0_read_enable && (!req1_read_enable || !prio1_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio1_d = prio1_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_q == 2'b00) begin
          if (pick0) begin
            grant_d = 2'b01;
            addr_d  = req0_address;
            prio1_d = 1'b1;
            state_d = ACCESS;
          end else if (req1_read_enable) begin
            grant_d = 2'b10;
            addr_d  = req1_address;
            prio1_d = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (memory_read_ready) begin
          rdata_d = memory_data;
          state_d = DONE;
        end
      end
      DONE: begin
        // Ownership ends with the completion pulse so RELEASE shows no grant
        grant_d = 2'b00;
        state_d = RELEASE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      prio1_q <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio1_q <= prio1_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode straight from registered state, so they change only on clock edges
  assign memory_read_enable = (state_q == ACCESS);
  assign memory_address     = addr_q;
  assign read_data          = rdata_q;
  assign grant              = grant_q;
  assign req0_read_ready    = (state_q == DONE) && grant_q[0];
  assign req1_read_ready    = (state_q == DONE) && grant_q[1];

endmodule
